banco_registradores: RTL and testbench

BANCO_REGISTRADORES -- requirements
Module: banco_registradores

---
 rtl/banco_registradores.sv | 84 ++++++++
 tb/tb_banco_registradores.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/banco_registradores.sv
`default_nettype none
// ============================================================================
// Module      : banco_registradores
// Description : 32 x 32-bit register file with two combinational read ports
//               and one synchronous write port. Register 0 is hard-wired to
//               zero. Register 29 ($sp) resets to 227. A saturating 8-bit
//               counter tracks the writes that were accepted since reset.
//
// Ports       : clock       - single clock; all state changes on rising edge
//               reset       - asynchronous reset, active low
//               escreve     - write enable
//               leitura1    - read address, port 1
//               leitura2    - read address, port 2
//               regEscrita  - write address
//               dadoEscrita - write data
//               dado1       - read data, port 1 (zero latency)
//               dado2       - read data, port 2 (zero latency)
//               escritas    - accepted-write counter, saturates at 8'hFF
//
// Build option: BANCO_REG_BYPASS_EN - when defined, a read of the register
//               being written in the same cycle returns dadoEscrita
//               (write-through forwarding). When undefined, reads return the
//               value held before the clock edge.
//
// Revision    : 1.0 - initial release
// ============================================================================
module banco_registradores (
    input  logic        clock,
    input  logic        reset,
    input  logic        escreve,
    input  logic [4:0]  leitura1,
    input  logic [4:0]  leitura2,
    input  logic [4:0]  regEscrita,
    input  logic [31:0] dadoEscrita,
    output logic [31:0] dado1,
    output logic [31:0] dado2,
    output logic [7:0]  escritas
);

    localparam logic [4:0]  ZERO_ADDR   = 5'd0;
    localparam logic [4:0]  SP_ADDR     = 5'd29;
    localparam logic [31:0] SP_RESET    = 32'd227;
    localparam logic [7:0]  COUNT_MAX   = 8'hFF;

    logic [31:0] regs [0:31];
    logic        write_accept;

    // A write to register 0 is a no-op: neither storage nor counter moves.
    // Reset is included so the forwarding path never exposes write data
    // while the file is being held in reset.
    assign write_accept = escreve && reset && (regEscrita != ZERO_ADDR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == int'(SP_ADDR)) ? SP_RESET : 32'd0;
            end
            escritas <= 8'd0;
        end else if (write_accept) begin
            regs[regEscrita] <= dadoEscrita;
            if (escritas != COUNT_MAX) begin
                escritas <= escritas + 8'd1;
            end
        end
    end

    // Register 0 is forced to zero at the read mux as well, so its value
    // never depends on the storage cell.
    always_comb begin
        dado1 = (leitura1 == ZERO_ADDR) ? 32'd0 : regs[leitura1];
        dado2 = (leitura2 == ZERO_ADDR) ? 32'd0 : regs[leitura2];
`ifdef BANCO_REG_BYPASS_EN
        // write_accept already excludes register 0, so the zero read holds.
        if (write_accept && (leitura1 == regEscrita)) begin
            dado1 = dadoEscrita;
        end
        if (write_accept && (leitura2 == regEscrita)) begin
            dado2 = dadoEscrita;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_banco_registradores.sv
`default_nettype none
// ============================================================================
// Module      : tb_banco_registradores
// Description : Self-checking bench for banco_registradores. A behavioural
//               model (array of register values plus an unbounded write
//               tally) predicts both read ports and the counter every cycle;
//               directed steps add hand-computed literal expectations.
//               Honours BANCO_REG_BYPASS_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_banco_registradores;

    logic        clock;
    logic        reset;
    logic        escreve;
    logic [4:0]  leitura1;
    logic [4:0]  leitura2;
    logic [4:0]  regEscrita;
    logic [31:0] dadoEscrita;
    logic [31:0] dado1;
    logic [31:0] dado2;
    logic [7:0]  escritas;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    banco_registradores dut (
        .clock       (clock),
        .reset       (reset),
        .escreve     (escreve),
        .leitura1    (leitura1),
        .leitura2    (leitura2),
        .regEscrita  (regEscrita),
        .dadoEscrita (dadoEscrita),
        .dado1       (dado1),
        .dado2       (dado2),
        .escritas    (escritas)
    );

    // 20 ns period: inputs change at negedge, literal checks at +2,
    // model checks at +5, mid-cycle reset at +7, posedge at +10.
    initial clock = 1'b0;
    always #10 clock = ~clock;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [31:0] m_regs [0:31];
    int          m_writes;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= (i == 29) ? 32'd227 : 32'd0;
            m_writes <= 0;
        end else if (escreve && regEscrita != 5'd0) begin
            m_regs[regEscrita] <= dadoEscrita;
            m_writes <= m_writes + 1;
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef BANCO_REG_BYPASS_EN
        if (reset && escreve && regEscrita == a) return dadoEscrita;
`endif
        return m_regs[a];
    endfunction

    function automatic logic [7:0] exp_count();
        return (m_writes > 255) ? 8'hFF : m_writes[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        #5;
        if (check_en) begin
            check("model dado1",    dado1,           exp_read(leitura1));
            check("model dado2",    dado2,           exp_read(leitura2));
            check("model escritas", {24'd0, escritas}, {24'd0, exp_count()});
        end
    end

    task automatic drive(input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] r1,
                         input logic [4:0] r2);
        @(negedge clock);
        escreve     = we;
        regEscrita  = wa;
        dadoEscrita = wd;
        leitura1    = r1;
        leitura2    = r2;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    initial begin
        reset = 1'b1; escreve = 1'b0; regEscrita = 5'd0;
        dadoEscrita = 32'd0; leitura1 = 5'd0; leitura2 = 5'd0;
        #1 reset = 1'b0;
        #1 check_en = 1'b1;

        // Reset contents, with a write attempt held off by reset
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 5'd8, 32'hFFFF_FFFF, 5'(a), 5'(31 - a));
            #2;
            check("reset dado1", dado1, (a == 29) ? 32'd227 : 32'd0);
            check("reset dado2", dado2, ((31 - a) == 29) ? 32'd227 : 32'd0);
        end
        check("reset escritas", {24'd0, escritas}, 32'd0);

        drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd8);
        reset = 1'b1;

        // Write/read on both ports
        drive(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd8);
        drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd8);
        #2;
        check("wr8 dado1", dado1, 32'hDEAD_BEEF);
        check("wr8 dado2", dado2, 32'hDEAD_BEEF);
        check("wr8 escritas", {24'd0, escritas}, 32'd1);

        // Register 0 write is ignored, never forwarded
        drive(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
        #2;
        check("reg0 fwd dado1", dado1, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd8);
        #2;
        check("reg0 dado1", dado1, 32'd0);
        check("reg0 escritas", {24'd0, escritas}, 32'd1);

        // Same-cycle read/write on register 31
        drive(1'b1, 5'd31, 32'd5, 5'd8, 5'd0);
        drive(1'b1, 5'd31, 32'd9, 5'd31, 5'd31);
        #2;
`ifdef BANCO_REG_BYPASS_EN
        check("rw31 before edge", dado1, 32'd9);
`else
        check("rw31 before edge", dado1, 32'd5);
`endif
        drive(1'b0, 5'd0, 32'd0, 5'd31, 5'd8);
        #2;
        check("rw31 after edge", dado1, 32'd9);
        check("rw31 escritas", {24'd0, escritas}, 32'd3);

        // Assorted patterns across the file
        for (int r = 2; r < 8; r++)
            drive(1'b1, 5'(r), 32'hA5A5_0000 | 32'(r * 17), 5'(r - 1), 5'(r));
        drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd2);
        #2;
        check("pat r7", dado1, 32'hA5A5_0000 | 32'd119);
        check("pat r2", dado2, 32'hA5A5_0000 | 32'd34);
        check("pat escritas", {24'd0, escritas}, 32'd9);

        // Counter saturation
        for (int i = 0; i < 300; i++)
            drive(1'b1, 5'd1, 32'(i), 5'd1, 5'd0);
        drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd1);
        #2;
        check("sat escritas", {24'd0, escritas}, 32'd255);
        check("sat r1", dado1, 32'd299);
        drive(1'b1, 5'd1, 32'd7, 5'd1, 5'd1);
        drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd1);
        #2;
        check("sat hold", {24'd0, escritas}, 32'd255);

        // Reset asserted between edges
        drive(1'b1, 5'd29, 32'd100, 5'd29, 5'd0);
        drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd29);
        #2;
        check("sp100", dado1, 32'd100);
        #5 reset = 1'b0;
        #1;
        check("midrst sp", dado1, 32'd227);
        check("midrst r8", (leitura2 == 5'd29) ? dado2 : 32'hX, 32'd227);
        check("midrst escritas", {24'd0, escritas}, 32'd0);
        drive(1'b1, 5'd29, 32'd55, 5'd29, 5'd8);
        drive(1'b1, 5'd29, 32'd55, 5'd29, 5'd8);
        #2;
        check("blocked sp", dado1, 32'd227);
        check("blocked r8", dado2, 32'd0);
        check("blocked escritas", {24'd0, escritas}, 32'd0);

        // Resume after reset release
        drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd8);
        reset = 1'b1;
        drive(1'b1, 5'd29, 32'd7, 5'd29, 5'd0);
        drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd0);
        #2;
        check("resume sp", dado1, 32'd7);
        check("resume escritas", {24'd0, escritas}, 32'd1);

        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        @(negedge clock);
        #6;
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
